imem_pipelined: RTL and testbench
=================================

Name: imem_pipelined

Overview:
- Parametrised, synchronous-read instruction memory for the MIPS datapath; successor to the combinational instruction ROM.
- Byte-addressed fetch requests enter through a valid/ready handshake, and responses leave through a valid/ready handshake after a configurable pipeline latency.
- A program-load write port lets the bench or boot logic fill the array at run time.
- Misaligned and out-of-range fetches are flagged and return a NOP instead of garbage.

Parameters:
- DATA_W, 32: instruction width in bits; multiple of 8, power of two.
- ADDR_W, 32: byte-address width of fetch requests.
- DEPTH, 256: number of instruction words; power of two.
- LATENCY, 2: accept-to-response latency in cycles; legal range 1..4.
- NOP_WORD, 0: word returned for faulted fetches.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when high together with req_valid.
- req_addr  in  ADDR_W  byte address of the fetch.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  DATA_W  fetched instruction.
- rsp_fault  out  2  bit0 = misaligned, bit1 = out of range.
- prog_en  in  1  write one word this cycle.
- prog_addr  in  clog2(DEPTH)  word index for the write.
- prog_data  in  DATA_W  write data.
- busy  out  1  at least one fetch is in flight or a response is pending.

Behaviour:
- Definitions:
  - BW = clog2(DATA_W/8).
  - Word index = req_addr >> BW.
  - Misaligned: req_addr[BW-1:0] != 0.
  - Out of range: word index >= DEPTH.
- Reset (async assert):
  - All stage-valid bits clear; rsp_valid=0, rsp_instr=0, rsp_fault=0, busy=0.
  - req_ready=0 while reset is high.
  - Array contents are not reset; they are retained across reset.
- Pipeline:
  - LATENCY stages. Stage 1 is loaded at the accept edge with the array word (or NOP_WORD) and the fault bits.
  - Each following stage is a register copy. The last stage drives the rsp_* outputs.
- Advance:
  - adv = !rsp_valid || rsp_ready. All stages shift together when adv=1 and hold when adv=0 (full stall, no bubbles collapse).
  - req_ready = adv && !prog_en && !reset.
- Accept:
  - Fires when req_valid && req_ready. rsp_valid rises exactly LATENCY cycles after the accept edge, provided there is no stall.
  - Back-to-back accepts give one response per cycle, in order.
- Backpressure: while rsp_valid && !rsp_ready, rsp_instr and rsp_fault hold stable and no request is accepted.
- Fault handling:
  - Any fault → rsp_instr = NOP_WORD. Both bits can be set together.
  - The array is not read for an out-of-range index; there is no aliasing.
- Program port:
  - Write occurs on the rising edge when prog_en=1. It has priority over fetch: req_ready is forced low that cycle.
  - In-flight fetches already captured their data and are unaffected.
  - A fetch accepted in the cycle after a write to the same word returns the new data.
- busy = OR of all stage-valid bits.
- Reset mid-operation: in-flight fetches are dropped and no response is emitted for them. Fetching resumes on the first clock after deassert.
- Parameter checks: an illegal LATENCY, DEPTH or DATA_W is a fatal elaboration error.

Test Plan:
- Reset, program words 0..3 = 0x11,0x22,0x33,0x44 via prog_en, then fetch addr 0,4,8,12 back-to-back with rsp_ready=1 → rsp_valid high from cycle 2 after the first accept; rsp_instr = 0x11,0x22,0x33,0x44 on consecutive cycles, rsp_fault=0.
- Fetch addr 6 → rsp_instr=NOP_WORD, rsp_fault=2'b01. Fetch addr 1024 (DEPTH=256) → NOP_WORD, rsp_fault=2'b10. Fetch addr 1026 → rsp_fault=2'b11.
- Stream 4 fetches, drop rsp_ready for 3 cycles after the first response → outputs hold 0x11, req_ready=0 during the stall, then 0x22..0x44 follow with no loss or duplication.
- Assert prog_en with req_valid high → req_ready=0 that cycle. Write 0x99 to word 1, fetch addr 4 on the next cycle → 0x99.
- Assert reset with 2 fetches in flight → rsp_valid and busy go 0 immediately, no stale response after release; fetching word 0 afterwards still returns 0x11.
- Rerun the first scenario with LATENCY=1 and LATENCY=4 → first rsp_valid at 1 and 4 cycles after accept respectively.

Source files
------------

// File: rtl/imem_pipelined.sv
// Synchronous-read instruction memory with valid/ready fetch and response handshakes,
// a LATENCY-deep stall-together pipeline, a run-time program-load port and fault flagging.
module imem_pipelined #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 256,
   parameter int                LATENCY  = 2,
   parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_W-1:0]        req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_instr,
   output logic [1:0]               rsp_fault,
   input  logic                     prog_en,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [DATA_W-1:0]        prog_data,
   output logic                     busy
);

   localparam int BW = $clog2(DATA_W / 8);
   localparam int IW = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] AMASK = ADDR_W'((64'd1 << BW) - 64'd1);

   generate
      if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
         $fatal(1, "imem_pipelined: LATENCY must be 1..4");
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $fatal(1, "imem_pipelined: DEPTH must be a power of two >= 2");
      end
      if (DATA_W < 8 || (DATA_W % 8) != 0 || ((DATA_W / 8) & (DATA_W / 8 - 1)) != 0) begin : g_bad_width
         $fatal(1, "imem_pipelined: DATA_W must be a power-of-two multiple of 8");
      end
   endgenerate

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [1:0]        fault;
   } stage_t;

   logic [DATA_W-1:0]    mem [DEPTH];
   stage_t [LATENCY:1]   stg;
   logic   [LATENCY:1]   vld_pipe;
   stage_t               fetch;
   logic [ADDR_W-1:0]    widx;
   logic                 mis, oor, adv, accept;

   assign widx = req_addr >> BW;
   assign mis  = |(req_addr & AMASK);
   // Any set bit above the index width means the word lies beyond DEPTH; no aliasing.
   assign oor  = |(widx >> IW);

   assign rsp_valid = vld_pipe[LATENCY];
   assign rsp_instr = stg[LATENCY].instr;
   assign rsp_fault = stg[LATENCY].fault;
   assign adv       = !rsp_valid || rsp_ready;
   assign req_ready = adv && !prog_en && !reset;
   assign accept    = req_valid && req_ready;
   assign busy      = |vld_pipe;

   always_comb begin
      fetch.fault = {oor, mis};
      fetch.instr = NOP_WORD;
      if (!mis && !oor)
         fetch.instr = mem[widx[IW-1:0]];
   end

   // Contents survive reset so a loaded program stays valid across a core restart.
   always_ff @(posedge clk) begin
      if (prog_en)
         mem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
         stg      <= '0;
      end else if (adv) begin
         vld_pipe[1] <= accept;
         if (accept)
            stg[1] <= fetch;
         for (int i = 2; i <= LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            stg[i]      <= stg[i-1];
         end
      end
   end

endmodule

// File: tb/tb_imem_pipelined.sv
// Runs one imem_pipelined per latency (1, 2, 4) with directed and random traffic,
// each checked every cycle against an in-order queue model of outstanding fetches.
module tb_imem_pipelined;

   localparam logic [31:0] NOP = 32'h0BAD_0BAD;

   typedef struct {
      logic [31:0] instr;
      logic [1:0]  fault;
      int          pos;
   } ent_t;

   logic clk = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   done [3];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_lat
      localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;

      logic        reset, req_valid, req_ready, rsp_valid, rsp_ready, prog_en, busy;
      logic [31:0] req_addr, rsp_instr, prog_data;
      logic [1:0]  rsp_fault;
      logic [7:0]  prog_addr;

      imem_pipelined #(
         .DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(LAT), .NOP_WORD(NOP)
      ) dut (
         .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
         .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
         .rsp_instr(rsp_instr), .rsp_fault(rsp_fault), .prog_en(prog_en),
         .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy)
      );

      // Reference: program image plus queue of accepted fetches, each tagged with how many
      // advancing edges it has seen; the head is presented once it has seen LAT of them.
      logic [31:0] mm [256];
      ent_t        q [$];

      function automatic string tg(input string s);
         return $sformatf("L%0d_%s", LAT, s);
      endfunction

      always @(negedge clk) begin
         bit   ev;
         ent_t e;
         ev = !reset && q.size() != 0 && q[0].pos == LAT;
         chk(tg("rsp_valid"), rsp_valid, ev);
         chk(tg("busy"), busy, !reset && q.size() != 0);
         chk(tg("req_ready"), req_ready, !reset && (!ev || rsp_ready) && !prog_en);
         if (ev) begin
            chk(tg("rsp_instr"), rsp_instr, q[0].instr);
            chk(tg("rsp_fault"), rsp_fault, q[0].fault);
         end
         if (reset) begin
            chk(tg("rst_instr"), rsp_instr, 0);
            chk(tg("rst_fault"), rsp_fault, 0);
            q.delete();
         end else if (!ev || rsp_ready) begin
            if (ev) void'(q.pop_front());
            foreach (q[i]) q[i].pos++;
            if (req_valid && !prog_en) begin
               e.fault[0] = (req_addr % 4) != 0;
               e.fault[1] = (req_addr / 4) >= 256;
               e.instr    = (e.fault != 0) ? NOP : mm[(req_addr / 4) % 256];
               e.pos      = 1;
               q.push_back(e);
            end
         end
         if (prog_en) mm[prog_addr] = prog_data;
      end

      task automatic cyc(input logic r, input logic rv, input logic [31:0] a, input logic rr,
                         input logic pe, input logic [7:0] pa, input logic [31:0] pd,
                         output logic acc);
         reset = r; req_valid = rv; req_addr = a; rsp_ready = rr;
         prog_en = pe; prog_addr = pa; prog_data = pd;
         #1 acc = req_valid && req_ready;
         @(posedge clk);
         #1;
      endtask

      task automatic run_seq(input logic [31:0] al [$], input bit stall);
         int   k = 0, held = 0;
         bit   seen = 0, rr;
         logic acc;
         while ((al.size() != 0 || busy) && k < 60) begin
            rr = !(stall && seen && held < 3);
            if (!rr) held++;
            cyc(0, al.size() != 0, (al.size() != 0) ? al[0] : 32'd0, rr, 0, 0, 0, acc);
            if (acc) void'(al.pop_front());
            if (rsp_valid) seen = 1;
            k++;
         end
         chk(tg("seq_drain"), k < 60, 1);
      endtask

      initial begin
         logic acc;
         int   n;
         logic [31:0] a;
         int   m;
         done[g] = 0;
         cyc(1, 0, 0, 1, 0, 0, 0, acc);
         cyc(1, 1, 0, 1, 0, 0, 0, acc);
         chk(tg("rst_no_accept"), acc, 0);
         cyc(0, 0, 0, 1, 0, 0, 0, acc);
         for (int i = 0; i < 256; i++) cyc(0, 0, 0, 1, 1, 8'(i), $urandom(), acc);
         for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 8'(i), 32'h11 * (i + 1), acc);

         // first-response latency from an empty pipeline
         cyc(0, 1, 0, 1, 0, 0, 0, acc);
         chk(tg("lat_accept"), acc, 1);
         n = 1;
         while (!rsp_valid && n < 8) begin
            cyc(0, 0, 0, 1, 0, 0, 0, acc);
            n++;
         end
         chk(tg("first_latency"), n, LAT);
         chk(tg("lat_instr"), rsp_instr, 32'h11);
         cyc(0, 0, 0, 1, 0, 0, 0, acc);

         run_seq('{0, 4, 8, 12}, 0);
         run_seq('{6, 1024, 1026}, 0);
         run_seq('{0, 4, 8, 12}, 1);

         cyc(0, 1, 4, 1, 1, 1, 32'h99, acc);
         chk(tg("prog_priority"), acc, 0);
         run_seq('{4}, 0);

         // reset with fetches in flight
         cyc(0, 1, 0, 1, 0, 0, 0, acc);
         cyc(0, 1, 4, 1, 0, 0, 0, acc);
         cyc(1, 0, 0, 1, 0, 0, 0, acc);
         chk(tg("midrst_valid"), rsp_valid, 0);
         chk(tg("midrst_busy"), busy, 0);
         cyc(0, 0, 0, 1, 0, 0, 0, acc);
         run_seq('{0}, 0);

         for (int i = 0; i < 1500; i++) begin
            m = $urandom_range(0, 9);
            a = (m < 8) ? {22'd0, 8'($urandom_range(0, 255)), 2'b00}
              : (m == 8) ? 32'($urandom_range(0, 1023)) : $urandom();
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, a,
                $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                8'($urandom_range(0, 255)), $urandom(), acc);
         end
         for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0, 0, 0, acc);
         chk(tg("final_idle"), busy, 0);
         done[g] = 1;
      end
   end

   initial begin
      int k;
      k = 0;
      while (!(done[0] && done[1] && done[2]) && k < 20000) begin
         @(posedge clk);
         k++;
      end
      chk("all_done", done[0] && done[1] && done[2], 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
